// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one WIDTH-bit adder across N_REQ requesters,
// with the result held in a one-entry output register tagged by the winner's index.
module adder_share_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_a_i,
  input  logic [N_REQ*WIDTH-1:0] req_b_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [IDW-1:0]         rsp_id_o,
  output logic [WIDTH-1:0]       rsp_sum_o,
  output logic                   rsp_carry_o
);
  typedef enum logic {EMPTY, FULL} state_e;
  state_e state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, grant, cand;
  logic [IDW:0] pos;
  logic [WIDTH-1:0] sum_q, sum_d, op_a, op_b;
  logic carry_q, carry_d, accept;
  // Offsets are walked high-to-low so the valid index nearest rr_ptr_q is the last one written.
  always_comb begin
    grant = '0;
    pos = '0;
    cand = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      cand = (pos >= (IDW+1)'(N_REQ)) ? IDW'(pos - (IDW+1)'(N_REQ)) : pos[IDW-1:0];
      if (req_valid_i[cand]) grant = cand;
    end
  end
  assign accept = (state_q == EMPTY || rsp_ready_i) && |req_valid_i;
  assign req_ready_o = accept ? {{(N_REQ-1){1'b0}}, 1'b1} << grant : '0;
  assign op_a = req_a_i[int'(grant)*WIDTH +: WIDTH];
  assign op_b = req_b_i[int'(grant)*WIDTH +: WIDTH];
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d = id_q;
    sum_d = sum_q;
    carry_d = carry_q;
    if (accept) begin
      state_d = FULL;
      rr_ptr_d = (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
      id_d = grant;
      {carry_d, sum_d} = {1'b0, op_a} + {1'b0, op_b};
    end else if (rsp_ready_i) begin
      state_d = EMPTY;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      rr_ptr_q <= '0;
      id_q <= '0;
      sum_q <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q <= id_d;
      sum_q <= sum_d;
      carry_q <= carry_d;
    end
  end
  assign rsp_valid_o = state_q == FULL;
  assign rsp_id_o = id_q;
  assign rsp_sum_o = sum_q;
  assign rsp_carry_o = carry_q;
endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb_adder_share_arbiter: directed and random checks of the shared-adder arbiter
// against a transaction-level model (rotating priority, one result slot).
module tb_adder_share_arbiter;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] valid = '0;
  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  logic [N*W-1:0] pa, pb;
  logic rsp_ready = 1'b0;
  logic [N-1:0] req_ready;
  logic rsp_valid, rsp_carry;
  logic [1:0] rsp_id;
  logic [W-1:0] rsp_sum;
  int n_chk = 0;
  int n_fail = 0;
  bit m_full;
  int m_rr, m_id, last_g;
  logic [W-1:0] m_sum;
  logic m_carry;

  adder_share_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(valid), .req_ready_o(req_ready),
    .req_a_i(pa), .req_b_i(pb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_sum_o(rsp_sum), .rsp_carry_o(rsp_carry)
  );

  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < N; i++) begin
      pa[i*W +: W] = a[i];
      pb[i*W +: W] = b[i];
    end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model: first valid requester at or after the pointer, circularly.
  function automatic int mgrant();
    for (int k = 0; k < N; k++)
      if (valid[(m_rr + k) % N]) return (m_rr + k) % N;
    return -1;
  endfunction

  function automatic bit maccept();
    return (!m_full || rsp_ready) && mgrant() >= 0;
  endfunction

  task automatic model_reset();
    m_full = 0; m_rr = 0; m_id = 0; m_sum = '0; m_carry = 1'b0; last_g = -1;
  endtask

  task automatic compare();
    logic [N-1:0] er;
    er = maccept() ? N'(1) << mgrant() : '0;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("rsp_sum", 64'(rsp_sum), 64'(m_sum));
    chk("rsp_carry", 64'(rsp_carry), 64'(m_carry));
  endtask

  task automatic update();
    logic [W:0] r;
    int g;
    if (!rst_n) begin
      model_reset();
    end else if (maccept()) begin
      g = mgrant();
      r = {1'b0, a[g]} + {1'b0, b[g]};
      m_sum = r[W-1:0];
      m_carry = r[W];
      m_id = g;
      m_full = 1;
      m_rr = (g + 1) % N;
      last_g = g;
    end else begin
      if (rsp_ready) m_full = 0;
      last_g = -1;
    end
  endtask

  task automatic tick();
    #1 compare();
    @(posedge clk);
    update();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1 model_reset();
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 3))
      0: return '1;
      1: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; end
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_valid", 64'(rsp_valid), 64'd0);
    chk("reset_id", 64'(rsp_id), 64'd0);
    chk("reset_sum", 64'(rsp_sum), 64'd0);
    chk("reset_carry", 64'(rsp_carry), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    // Single add, then wrap and no-wrap edge cases.
    valid = 4'b0001; a[0] = 3; b[0] = 4; rsp_ready = 1'b1;
    #1 chk("t1_ready", 64'(req_ready), 64'b0001);
    tick();
    valid = '0;
    chk("t1_valid", 64'(rsp_valid), 64'd1);
    chk("t1_id", 64'(rsp_id), 64'd0);
    chk("t1_sum", 64'(rsp_sum), 64'd7);
    chk("t1_carry", 64'(rsp_carry), 64'd0);
    valid = 4'b0010; a[1] = 32'hFFFF_FFFF; b[1] = 1;
    tick();
    chk("t2_sum", 64'(rsp_sum), 64'h0);
    chk("t2_carry", 64'(rsp_carry), 64'd1);
    chk("t2_id", 64'(rsp_id), 64'd1);
    a[1] = 32'h7FFF_FFFF;
    tick();
    valid = '0;
    chk("t2b_sum", 64'(rsp_sum), 64'h8000_0000);
    chk("t2b_carry", 64'(rsp_carry), 64'd0);
    tick();
    // All requesters valid from reset: strict rotation.
    do_reset();
    valid = 4'b1111;
    for (int i = 0; i < N; i++) begin a[i] = W'(i * 16 + 1); b[i] = W'(i); end
    for (int k = 0; k < 5; k++) begin
      #1 chk("t3_grant", 64'(req_ready), 64'(1) << (k % 4));
      tick();
      chk("t3_id", 64'(rsp_id), 64'(k % 4));
    end
    // Back-pressure holds the result and blocks grants; release accepts same cycle.
    valid = 4'b0100; rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("t4_ready_low", 64'(req_ready), 64'd0);
      tick();
      chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
      chk("t4_hold_id", 64'(rsp_id), 64'd0);
      chk("t4_hold_sum", 64'(rsp_sum), 64'd1);
    end
    rsp_ready = 1'b1;
    #1 chk("t4_release_ready", 64'(req_ready), 64'b0100);
    tick();
    chk("t4_id", 64'(rsp_id), 64'd2);
    chk("t4_sum", 64'(rsp_sum), 64'd35);
    // Pointer at 3 with only req1 valid, then req0/req2 -> req2.
    valid = 4'b0010;
    #1 chk("t5_grant1", 64'(req_ready), 64'b0010);
    tick();
    valid = 4'b0101;
    #1 chk("t5_grant2", 64'(req_ready), 64'b0100);
    tick();
    chk("t5_id", 64'(rsp_id), 64'd2);
    // Reset while full with requests pending.
    valid = 4'b1001; rsp_ready = 1'b0;
    tick();
    do_reset();
    rsp_ready = 1'b1;
    #1 chk("t6_grant", 64'(req_ready), 64'b0001);
    tick();
    chk("t6_id", 64'(rsp_id), 64'd0);
    // Random traffic honouring the hold-until-granted contract.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (!valid[i] || last_g == i) begin
          valid[i] = $urandom_range(0, 2) != 0;
          a[i] = rnd();
          b[i] = rnd();
        end
      rsp_ready = $urandom_range(0, 3) != 0;
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
